// File: rtl/bot_trail_pkg.sv
// Shared types and defaults for the RojoBot breadcrumb trail recorder.
// Optional macro TRAIL_FADE_EN enables age-bucket reporting in the match stage.
package bot_trail_pkg;

    localparam int TRAIL_DEPTH_DEF = 16;
    localparam int AGE_W           = 2;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } trail_entry_t;

endpackage

// File: rtl/bot_trail_match.sv
// Combinational compare of one query position against every trail entry.
// With TRAIL_FADE_EN defined, also selects the newest match and reports its age bucket.
module bot_trail_match
    import bot_trail_pkg::*;
#(
    parameter int DEPTH = TRAIL_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  trail_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]         valid,
    input  logic [AW-1:0]            wr_ptr,
    input  logic [7:0]               qry_x,
    input  logic [7:0]               qry_y,
    output logic                     hit,
    output logic [AGE_W-1:0]         age
);

    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = valid[i] & (entries[i].x == qry_x) & (entries[i].y == qry_y);
    end

    assign hit = |match;

`ifdef TRAIL_FADE_EN
    logic [AW-1:0] dist;
    logic [AW-1:0] best;
    logic          found;

    // Distance back from the most recent write; the smallest one is the newest match.
    always_comb begin
        dist  = '0;
        best  = '1;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            dist = wr_ptr - AW'(1) - AW'(i);
            if (match[i] && (!found || dist < best)) begin
                best  = dist;
                found = 1'b1;
            end
        end
        age = found ? best[AW-1:AW-2] : '0;
    end
`else
    logic unused_wr_ptr;
    assign unused_wr_ptr = ^wr_ptr;
    assign age           = '0;
`endif

endmodule

// File: rtl/bot_trail_recorder.sv
// Records the most recent distinct RojoBot positions and answers per-pixel trail queries.
// Build option: TRAIL_FADE_EN (age-bucket output; otherwise hit_age is tied low).
module bot_trail_recorder
    import bot_trail_pkg::*;
#(
    parameter  int DEPTH = TRAIL_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_sysregs,
    input  logic [7:0]       LocX_reg,
    input  logic [7:0]       LocY_reg,
    input  logic             trail_en,
    input  logic             trail_clr,
    input  logic             qry_valid,
    input  logic [7:0]       qry_x,
    input  logic [7:0]       qry_y,
    output logic             hit_valid,
    output logic             hit,
    output logic [AGE_W-1:0] hit_age,
    output logic [AW:0]      trail_count
);

    trail_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]              count_q, count_d;
    logic                     upd_q, upd_d;
    logic [7:0]               last_x_q, last_x_d;
    logic [7:0]               last_y_q, last_y_d;
    logic                     have_last_q, have_last_d;
    logic                     hit_valid_q, hit_valid_d;
    logic                     hit_q, hit_d;
    logic [AGE_W-1:0]         hit_age_q, hit_age_d;

    logic             upd_event;
    logic             record;
    logic             match_hit;
    logic [AGE_W-1:0] match_age;

    // Queries see the pre-write buffer because the matcher looks at the flops.
    bot_trail_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .entries (entries_q),
        .valid   (valid_q),
        .wr_ptr  (wr_ptr_q),
        .qry_x   (qry_x),
        .qry_y   (qry_y),
        .hit     (match_hit),
        .age     (match_age)
    );

    assign upd_event = upd_sysregs & ~upd_q;
    assign record    = upd_event & trail_en & ~trail_clr &
                       (~have_last_q | (LocX_reg != last_x_q) | (LocY_reg != last_y_q));

    always_comb begin
        upd_d       = upd_sysregs;
        entries_d   = entries_q;
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        last_x_d    = last_x_q;
        last_y_d    = last_y_q;
        have_last_d = have_last_q;

        if (trail_clr) begin
            valid_d     = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            have_last_d = 1'b0;
        end else if (record) begin
            entries_d[wr_ptr_q] = '{x: LocX_reg, y: LocY_reg};
            valid_d[wr_ptr_q]   = 1'b1;
            wr_ptr_d            = wr_ptr_q + AW'(1);
            last_x_d            = LocX_reg;
            last_y_d            = LocY_reg;
            have_last_d         = 1'b1;
            // Once full, new writes overwrite the oldest slot and the count holds.
            if (count_q != (AW+1)'(DEPTH))
                count_d = count_q + (AW+1)'(1);
        end

        hit_valid_d = qry_valid;
        hit_d       = qry_valid & match_hit;
        hit_age_d   = qry_valid ? match_age : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            upd_q       <= 1'b0;
            last_x_q    <= '0;
            last_y_q    <= '0;
            have_last_q <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_age_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            upd_q       <= upd_d;
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            have_last_q <= have_last_d;
            hit_valid_q <= hit_valid_d;
            hit_q       <= hit_d;
            hit_age_q   <= hit_age_d;
        end
    end

    // Entry payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign hit_valid   = hit_valid_q;
    assign hit         = hit_q;
    assign hit_age     = hit_age_q;
    assign trail_count = count_q;

endmodule

// File: tb/tb_bot_trail_recorder.sv
// Self-checking bench for bot_trail_recorder: directed table, corner sequences, random vs queue model.
module tb_bot_trail_recorder;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             upd_sysregs = 1'b0;
    logic [7:0]       LocX_reg = '0;
    logic [7:0]       LocY_reg = '0;
    logic             trail_en = 1'b1;
    logic             trail_clr = 1'b0;
    logic             qry_valid = 1'b0;
    logic [7:0]       qry_x = '0;
    logic [7:0]       qry_y = '0;
    logic             hit_valid;
    logic             hit;
    logic [1:0]       hit_age;
    logic [AW:0]      trail_count;

    bot_trail_recorder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_sysregs (upd_sysregs),
        .LocX_reg    (LocX_reg),
        .LocY_reg    (LocY_reg),
        .trail_en    (trail_en),
        .trail_clr   (trail_clr),
        .qry_valid   (qry_valid),
        .qry_x       (qry_x),
        .qry_y       (qry_y),
        .hit_valid   (hit_valid),
        .hit         (hit),
        .hit_age     (hit_age),
        .trail_count (trail_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       upd;
        bit [7:0] x, y;
        bit       en, clr, qv;
        bit [7:0] qx, qy;
        bit       e_hit;
        int       e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: newest position at the back of the queue.
    bit [15:0] m_q[$];
    bit        m_upd_prev;
    bit [7:0]  m_lx, m_ly;
    bit        m_have;
    bit        m_hv, m_hit;
    int        m_age;

    function automatic vec_t mkv(bit upd, int x, int y, bit en, bit clr, bit qv,
                                 int qx, int qy, bit ehit, int ecnt);
        vec_t v;
        v.upd = upd; v.x = 8'(x); v.y = 8'(y); v.en = en; v.clr = clr;
        v.qv = qv; v.qx = 8'(qx); v.qy = 8'(qy); v.e_hit = ehit; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_upd_prev = 1'b0;
        m_lx = '0; m_ly = '0; m_have = 1'b0;
    endtask

    task automatic model_step(input vec_t v);
        bit ev;
        m_hv  = v.qv;
        m_hit = 1'b0;
        m_age = 0;
        if (v.qv) begin
            for (int k = 0; k < m_q.size(); k++) begin
                if (m_q[m_q.size()-1-k] == {v.qx, v.qy}) begin
                    m_hit = 1'b1;
`ifdef TRAIL_FADE_EN
                    m_age = (k * 4) / DEPTH;
`endif
                    break;
                end
            end
        end
        ev = v.upd && !m_upd_prev;
        m_upd_prev = v.upd;
        if (v.clr) begin
            m_q.delete();
            m_have = 1'b0;
        end else if (ev && v.en && (!m_have || v.x != m_lx || v.y != m_ly)) begin
            m_q.push_back({v.x, v.y});
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            m_lx = v.x; m_ly = v.y; m_have = 1'b1;
        end
    endtask

    task automatic apply(input vec_t v, input bit use_tbl, input string tag);
        upd_sysregs = v.upd; LocX_reg = v.x; LocY_reg = v.y;
        trail_en = v.en; trail_clr = v.clr;
        qry_valid = v.qv; qry_x = v.qx; qry_y = v.qy;
        model_step(v);
        @(posedge clk);
        #1;
        check({tag, ".hv"},  int'(hit_valid),   int'(m_hv));
        check({tag, ".hit"}, int'(hit),         int'(m_hit));
        check({tag, ".age"}, int'(hit_age),     m_age);
        check({tag, ".cnt"}, int'(trail_count), m_q.size());
        if (use_tbl) begin
            check({tag, ".tbl_hit"}, int'(hit),         int'(v.e_hit));
            check({tag, ".tbl_cnt"}, int'(trail_count), v.e_cnt);
            check({tag, ".tbl_age"}, int'(hit_age),     0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        upd_sysregs = 1'b0; trail_clr = 1'b0; qry_valid = 1'b0; trail_en = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        do_reset();
        check("reset.hv",  int'(hit_valid),   0);
        check("reset.hit", int'(hit),         0);
        check("reset.age", int'(hit_age),     0);
        check("reset.cnt", int'(trail_count), 0);

        // Directed table
        for (int k = 0; k < 5; k++) tbl.push_back(mkv(1, 10, 20, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(0, 10, 20, 1, 0, 1, 10, 20, 1, 1));
        tbl.push_back(mkv(0, 10, 20, 1, 0, 1, 10, 21, 0, 1));
        for (int k = 0; k < 6; k++) tbl.push_back(mkv(k % 2 == 0, 10, 20, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(1, 11, 20, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mkv(0, 11, 20, 1, 0, 1, 11, 20, 1, 2));
        tbl.push_back(mkv(0, 11, 20, 1, 0, 1, 10, 20, 1, 2));
        tbl.push_back(mkv(1, 11, 20, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(0, 11, 20, 1, 0, 1, 11, 20, 0, 0));
        tbl.push_back(mkv(1, 11, 20, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mkv(0, 11, 20, 1, 0, 1, 11, 20, 1, 1));
        tbl.push_back(mkv(1, 5, 5, 1, 0, 1, 5, 5, 0, 2));
        tbl.push_back(mkv(0, 5, 5, 1, 0, 1, 5, 5, 1, 2));
        for (int k = 0; k < 8; k++) tbl.push_back(mkv(k % 2 == 0, 40 + k, 40 + k, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mkv(0, 0, 0, 1, 0, 1, 40, 40, 0, 2));
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], 1'b1, $sformatf("tbl%0d", k));

        // Wrap-around: 20 distinct positions into a 16-entry buffer
        apply(mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, "wrap.clr");
        for (int i = 0; i < 20; i++) begin
            apply(mkv(1, i, i, 1, 0, 0, 0, 0, 0, 0), 1'b0, "wrap.wr");
            apply(mkv(0, i, i, 1, 0, 0, 0, 0, 0, 0), 1'b0, "wrap.lo");
        end
        check("wrap.cnt", int'(trail_count), 16);
        apply(mkv(0, 0, 0, 1, 0, 1, 3, 3, 0, 0), 1'b0, "wrap.q3");
        check("wrap.q3_hit", int'(hit), 0);
        apply(mkv(0, 0, 0, 1, 0, 1, 4, 4, 0, 0), 1'b0, "wrap.q4");
        check("wrap.q4_hit", int'(hit), 1);
`ifdef TRAIL_FADE_EN
        check("wrap.q4_age", int'(hit_age), 3);
`else
        check("wrap.q4_age", int'(hit_age), 0);
`endif
        apply(mkv(0, 0, 0, 1, 0, 1, 19, 19, 0, 0), 1'b0, "wrap.q19");
        check("wrap.q19_hit", int'(hit), 1);
        check("wrap.q19_age", int'(hit_age), 0);

        // Asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.hv",  int'(hit_valid),   0);
        check("arst.hit", int'(hit),         0);
        check("arst.age", int'(hit_age),     0);
        check("arst.cnt", int'(trail_count), 0);
        do_reset();
        apply(mkv(1, 7, 9, 1, 0, 0, 0, 0, 0, 0), 1'b0, "arst.first");
        check("arst.first_cnt", int'(trail_count), 1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            v.upd = 1'($urandom % 2);
            v.x   = 8'($urandom_range(0, 5));
            v.y   = 8'($urandom_range(0, 5));
            if ($urandom % 16 == 0) v.x = v.x | 8'h80;
            v.en  = ($urandom_range(0, 9) != 0);
            v.clr = ($urandom_range(0, 59) == 0);
            v.qv  = 1'($urandom % 2);
            v.qx  = 8'($urandom_range(0, 5));
            v.qy  = 8'($urandom_range(0, 5));
            if ($urandom % 8 == 0) v.qx = v.qx | 8'h80;
            v.e_hit = 1'b0; v.e_cnt = 0;
            apply(v, 1'b0, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
